// File: rtl/snake_dir_input.sv
// snake_dir_input: synchronises and debounces the four active-low direction
// buttons, turns debounced presses into a direction request, and commits
// that request on the game step strobe. 180-degree reversals are rejected.

// Per-button synchroniser + debouncer; pulses press on a stable 1->0 change.
module snake_dir_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; released level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;   // only the falling (pressed) edge pulses
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module snake_dir_input #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       CLK1_50,
    input  logic       CLR_N,
    input  logic [3:0] KEY,
    input  logic       step,
    output logic [3:0] press,
    output logic [1:0] dir,
    output logic       dir_pending
);
    logic [1:0] next_dir;
    logic [1:0] win_code;
    logic       win_vld;
    logic [1:0] dir_eff;
    logic       commit;
    logic       accept;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_btn
            snake_dir_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (CLK1_50),
                .rst_n (CLR_N),
                .key   (KEY[g]),
                .press (press[g])
            );
        end
    endgenerate

    // Pick the lowest-index press and test it against the effective direction,
    // which is the pending request when this same cycle commits it.
    always_comb begin
        win_code = 2'b00;
        win_vld  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                win_code = 2'(i);
                win_vld  = 1'b1;
            end
        end
        commit  = step && dir_pending;
        dir_eff = commit ? next_dir : dir;
        accept  = win_vld && (win_code != (dir_eff ^ 2'b10));
    end

    // Latch accepted requests and commit the pending one on step.
    always_ff @(posedge CLK1_50 or negedge CLR_N) begin
        if (!CLR_N) begin
            dir         <= 2'b01;
            next_dir    <= 2'b01;
            dir_pending <= 1'b0;
        end else begin
            if (commit) begin
                dir <= next_dir;
            end
            if (accept) begin
                next_dir    <= win_code;
                dir_pending <= 1'b1;
            end else if (commit) begin
                dir_pending <= 1'b0;
            end
        end
    end
endmodule

// File: doc/snake_dir_input.md
# snake_dir_input

Input-side front end for the snake game box: reads the four raw active-low pushbuttons, synchronises and debounces each one, and turns debounced presses into a direction request for the game logic. The current direction is committed on the game's step strobe, which is the same enable tick that advances the display. Presses that would reverse the snake 180° are rejected.

## Interface
- DEB_CYCLES, 1000000, number of consecutive clock cycles a synchronised level must differ from the stable level before it is accepted (20 ms at 50 MHz); minimum 2.
- CLK1_50  input  1  system clock, 50 MHz; all state on rising edge.
- CLR_N  input  1  asynchronous, active-low reset.
- KEY  input  4  raw pushbuttons, active-low. Index = direction code: 0=up, 1=right, 2=down, 3=left.
- step  input  1  one-cycle game-step strobe; commits a pending request.
- press  output  4  one-cycle pulse per debounced press (1→0 stable transition), per button.
- dir  output  2  committed direction (00 up, 01 right, 10 down, 11 left).
- dir_pending  output  1  a request is latched and waiting for step.

## Operation
- Reset values (CLR_N=0, immediate):
  - sync flops and stable levels = 1 (released).
  - debounce counters = 0.
  - press = 0000.
  - dir = 01 (right).
  - next_dir = 01; dir_pending = 0.
- Synchroniser: two flops per KEY bit.
- Debounce, per button:
  - If the synchronised level equals stable, the counter clears to 0.
  - Otherwise, if counter = DEB_CYCLES−1: stable takes the new level and the counter clears; else the counter increments.
  - Counter width is clog2(DEB_CYCLES); the counter never wraps.
- press[i] is registered and asserts in the same clock as stable[i] goes 1→0. Release (0→1) produces no pulse. A held button yields exactly one pulse.
- Request logic, evaluated on the cycle press is high:
  - Let dir_eff = next_dir if (step && dir_pending), else dir.
  - If several press bits are set in one cycle, the lowest index wins and the others are dropped.
  - Winning code c is rejected if c == dir_eff ^ 2'b10 (reversal). Otherwise next_dir←c and dir_pending←1.
  - A press equal to dir_eff is accepted (harmless).
  - Later accepted presses before a step overwrite next_dir (last wins).
- Step:
  - If dir_pending: dir←next_dir and dir_pending←0, unless the same cycle also accepts a new press; in that case dir_pending stays 1 with the new next_dir.
  - step with no pending request: no change.
- Reset asserted mid-debounce discards all partial counts. After release, a still-held key needs a full DEB_CYCLES qualification and then produces one press.

## Timing
- Take a KEY[i] edge that is steady from sampling edge k.
  - Synchronised level changes after edge k+1.
  - stable and press[i] update at edge k+1+DEB_CYCLES.
  - press[i] is high for exactly one cycle.
- next_dir/dir_pending update at edge k+2+DEB_CYCLES (one cycle after press).
- dir updates on the edge where step=1 and dir_pending=1. It is visible in the following cycle.
- Glitches: any synchronised excursion shorter than DEB_CYCLES cycles is ignored and its counter restarts.
- No combinational path from KEY or step to any output.

## Test plan
(DEB_CYCLES=4 in all scenarios)
- Reset: CLR_N=0 with KEY=0000 and step=1 → dir=01, dir_pending=0, press=0000. Release reset with keys still held → after 5 cycles press=1111 for one cycle. Only press[0] is acted on, because the lowest index wins: next_dir=00, dir_pending=1.
- Clean press: KEY[2] low from edge k for 10 cycles → press=0100 only after edge k+5, dir_pending=1 after k+6. Pulse step at k+8 → dir=10 and dir_pending=0 after k+8.
- Bounce: KEY[0] toggling low 3 cycles / high 1 cycle for 40 cycles → press stays 0000 and dir_pending stays 0.
- Reversal: dir=01, press KEY[3] → press[3] pulses, dir_pending stays 0. A following step leaves dir=01.
- Last-wins and same-cycle: dir=01; accept up (00), then down (10) before step → next_dir=10. Step → dir=10. Next, arrange step in the same cycle that press[0] (up) fires while pending=10 → dir=10, press rejected as reversal, dir_pending=0.
- Reset mid-debounce: KEY[1] low; assert CLR_N for 1 cycle at counter=2 → no press at the original deadline. press[1] occurs 5 cycles after reset release.
